uart_rx_pkt_ctrl: RTL and testbench
===================================

Name: uart_rx_pkt_ctrl

Overview:
- Packet controller that sits directly behind the top-level UART receiver (`top`) and sequences it.
- Drives the receiver enable and consumes its per-byte strobe.
- Frames the byte stream as SYNC | LEN | PAYLOAD[LEN] | CHK and stores the payload in an internal buffer.
- Presents a completed packet to downstream logic through a read port until it is acknowledged.

Parameters:
- PAYLOAD_BITS, 8, width of a UART byte.
- MAX_LEN, 16, maximum payload length in bytes.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYC, 84375, max CLK_I cycles between bytes inside a packet (3 byte times at 27 MHz / 9600 baud).
- Derived: LW = $clog2(MAX_LEN+1); AW = $clog2(MAX_LEN).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous, active-high reset.
- EN_I  in  1  controller enable.
- RX_EN_O  out  1  enable to the UART receiver (RX_EN_I of `top`).
- RX_VALID_I  in  1  one-cycle strobe: a received byte is on RX_DATA_I.
- RX_DATA_I  in  PAYLOAD_BITS  received byte.
- PKT_VALID_O  out  1  a checked packet is held in the buffer.
- PKT_LEN_O  out  LW  payload length of the held packet.
- RD_ADDR_I  in  AW  buffer read address.
- RD_DATA_O  out  PAYLOAD_BITS  buffer read data, registered.
- PKT_ACK_I  in  1  release the held packet.
- BUSY_O  out  1  packet reception in progress.
- ERR_LEN_O  out  1  one-cycle pulse: illegal LEN.
- ERR_CHK_O  out  1  one-cycle pulse: checksum mismatch.
- ERR_TMO_O  out  1  one-cycle pulse: inter-byte timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including RD_DATA_O; counters and checksum cleared. Buffer contents need not be cleared.
- RX_EN_O = EN_I && state != HOLD, combinational from registered state.
- BUSY_O = 1 in LEN, PAY and CHK.
- States:
  - IDLE: on RX_VALID_I with RX_DATA_I == SYNC_BYTE -> LEN. Any other byte is discarded, stay IDLE.
  - LEN: on byte: if 1 <= byte <= MAX_LEN, latch length, chk = byte, idx = 0 -> PAY. Otherwise pulse ERR_LEN_O -> IDLE. SYNC_BYTE is treated as a length value here, not as a resync.
  - PAY: on byte: buf[idx] = byte, chk ^= byte, idx++. When idx reaches length-1 on that write -> CHK.
  - CHK: on byte: if byte == chk, assert PKT_VALID_O -> HOLD. Otherwise pulse ERR_CHK_O -> IDLE.
  - HOLD: PKT_VALID_O = 1 and PKT_LEN_O = length, both stable. RX_EN_O = 0 and RX_VALID_I is ignored. PKT_ACK_I -> IDLE; PKT_VALID_O falls in the cycle after ACK is sampled. PKT_ACK_I in any other state is ignored.
- Checksum is the XOR of the LEN byte and every payload byte.
- PKT_LEN_O holds the last accepted length; it is meaningful only while PKT_VALID_O is high.
- Read port: RD_DATA_O <= buf[RD_ADDR_I] every cycle, 1-cycle latency. RD_ADDR_I >= length returns stale data, no error.
- Timeout:
  - Counter active in LEN, PAY and CHK; cleared on every RX_VALID_I and on entry to LEN.
  - When it reaches TIMEOUT_CYC-1 with no byte: pulse ERR_TMO_O -> IDLE.
  - If RX_VALID_I coincides with expiry, the byte wins and there is no timeout.
- EN_I low: in any state except HOLD, go to IDLE next cycle with no error pulse. HOLD is kept until ACK regardless of EN_I.
- Error outputs are mutually exclusive, exactly one cycle wide, and registered.

Test Plan:
1. EN_I=1; bytes A5 03 11 22 33 03 -> PKT_VALID_O=1, PKT_LEN_O=3, RD_ADDR_I 0/1/2 returns 11/22/33 one cycle later, no error pulses.
2. Bytes 00 FF A5 01 7E 7F -> leading 00 and FF are discarded; PKT_VALID_O=1, len 1, buf[0]=7E.
3. A5 02 AA 55 00 (expected CHK FD) -> one ERR_CHK_O pulse, PKT_VALID_O stays 0, state IDLE. A following valid packet is accepted.
4. A5 00 and A5 11 (17 > MAX_LEN) -> one ERR_LEN_O pulse each, back to IDLE.
5. TIMEOUT_CYC=50; A5 02 10 then silence -> ERR_TMO_O pulses exactly 49 cycles after the 10 strobe. Repeat with a byte arriving in that same cycle -> no timeout.
6. In HOLD, inject byte 44 -> ignored, RX_EN_O=0, buffer unchanged. Pulse PKT_ACK_I -> PKT_VALID_O=0 next cycle, RX_EN_O=1. Assert RST_I mid-PAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SYNC | LEN | PAYLOAD | CHK.
// Holds a checked payload in a local buffer until downstream acknowledges it.
module uart_rx_pkt_ctrl #(
  parameter int                      PAYLOAD_BITS = 8,
  parameter int                      MAX_LEN      = 16,
  parameter logic [PAYLOAD_BITS-1:0] SYNC_BYTE    = 8'hA5,
  parameter int                      TIMEOUT_CYC  = 84375,
  localparam int                     LW = $clog2(MAX_LEN + 1),
  localparam int                     AW = $clog2(MAX_LEN)
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    EN_I,
  output logic                    RX_EN_O,
  input  logic                    RX_VALID_I,
  input  logic [PAYLOAD_BITS-1:0] RX_DATA_I,
  output logic                    PKT_VALID_O,
  output logic [LW-1:0]           PKT_LEN_O,
  input  logic [AW-1:0]           RD_ADDR_I,
  output logic [PAYLOAD_BITS-1:0] RD_DATA_O,
  input  logic                    PKT_ACK_I,
  output logic                    BUSY_O,
  output logic                    ERR_LEN_O,
  output logic                    ERR_CHK_O,
  output logic                    ERR_TMO_O
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CHK,
    S_HOLD
  } state_e;

  state_e                  state_q;
  logic [LW-1:0]           len_q;
  logic [AW-1:0]           idx_q;
  logic [PAYLOAD_BITS-1:0] chk_q;
  logic [PAYLOAD_BITS-1:0] rd_q;
  logic [TW-1:0]           cnt_q;
  logic [TW-1:0]           cnt_d;
  logic                    pkt_q;
  logic                    elen_q;
  logic                    echk_q;
  logic                    etmo_q;
  logic                    run_q;

  logic [PAYLOAD_BITS-1:0] mem_q [MAX_LEN];

  logic busy;
  logic len_ok;
  logic last;
  logic tmo_hit;
  logic wr_en;

  assign busy    = (state_q == S_LEN) || (state_q == S_PAY)
                || (state_q == S_CHK);
  assign len_ok  = (RX_DATA_I != '0)
                && (RX_DATA_I <= PAYLOAD_BITS'(MAX_LEN));
  assign last    = (LW'(idx_q) == len_q - LW'(1));
  assign cnt_d   = cnt_q + TW'(1);
  assign tmo_hit = (cnt_d == TW'(TIMEOUT_CYC - 1));
  assign wr_en   = EN_I && RX_VALID_I && (state_q == S_PAY);

  // run_q keeps the receiver disabled until the first clock after reset
  assign RX_EN_O     = EN_I && run_q && (state_q != S_HOLD);
  assign BUSY_O      = busy;
  assign PKT_VALID_O = pkt_q;
  assign PKT_LEN_O   = len_q;
  assign RD_DATA_O   = rd_q;
  assign ERR_LEN_O   = elen_q;
  assign ERR_CHK_O   = echk_q;
  assign ERR_TMO_O   = etmo_q;

  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      mem_q[idx_q] <= RX_DATA_I;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[RD_ADDR_I];
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      pkt_q   <= 1'b0;
      elen_q  <= 1'b0;
      echk_q  <= 1'b0;
      etmo_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      elen_q <= 1'b0;
      echk_q <= 1'b0;
      etmo_q <= 1'b0;

      if (busy && !RX_VALID_I) begin
        cnt_q <= cnt_d;
      end else begin
        cnt_q <= '0;
      end

      if (!EN_I && (state_q != S_HOLD)) begin
        state_q <= S_IDLE;
      end else if (busy && !RX_VALID_I && tmo_hit) begin
        etmo_q  <= 1'b1;
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (RX_VALID_I && (RX_DATA_I == SYNC_BYTE)) begin
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (RX_VALID_I) begin
              if (len_ok) begin
                len_q   <= LW'(RX_DATA_I);
                chk_q   <= RX_DATA_I;
                idx_q   <= '0;
                state_q <= S_PAY;
              end else begin
                elen_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          S_PAY: begin
            if (RX_VALID_I) begin
              chk_q <= chk_q ^ RX_DATA_I;
              idx_q <= idx_q + AW'(1);
              if (last) begin
                state_q <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (RX_VALID_I) begin
              if (RX_DATA_I == chk_q) begin
                pkt_q   <= 1'b1;
                state_q <= S_HOLD;
              end else begin
                echk_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
          S_HOLD: begin
            if (PKT_ACK_I) begin
              pkt_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: expected packets, errors and
// read data are queued by the stimulus and popped by a negedge monitor.
module tb_uart_rx_pkt_ctrl;

  localparam int TMO    = 50;
  localparam int EV_PKT = 0;
  localparam int EV_LEN = 1;
  localparam int EV_CHK = 2;
  localparam int EV_TMO = 3;

  typedef struct {
    int kind;
    int len;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic       pkt_ack;
  logic       rd_req;
  logic       rd_req_q = 1'b0;

  logic       rx_en;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic [7:0] rd_data;
  logic       busy;
  logic       err_len;
  logic       err_chk;
  logic       err_tmo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = 0;

  ev_t        evq[$];
  logic [7:0] rdq[$];
  logic [7:0] stim[$];

  logic pkt_prev = 1'b0;
  logic [2:0] err_prev = 3'b000;

  uart_rx_pkt_ctrl #(
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .EN_I       (en),
    .RX_EN_O    (rx_en),
    .RX_VALID_I (rx_valid),
    .RX_DATA_I  (rx_data),
    .PKT_VALID_O(pkt_valid),
    .PKT_LEN_O  (pkt_len),
    .RD_ADDR_I  (rd_addr),
    .RD_DATA_O  (rd_data),
    .PKT_ACK_I  (pkt_ack),
    .BUSY_O     (busy),
    .ERR_LEN_O  (err_len),
    .ERR_CHK_O  (err_chk),
    .ERR_TMO_O  (err_tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d required none", kind);
    end else begin
      e = evq.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == EV_PKT) chk("pkt_len", 32'(pkt_len), e.len);
      if (e.kind == EV_TMO) chk("tmo_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [7:0] exp_rd;
    if (rst) begin
      pkt_prev = 1'b0;
      err_prev = 3'b000;
    end else begin
      if (rd_req_q) begin
        if (rdq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h required none", rd_data);
        end else begin
          exp_rd = rdq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(exp_rd));
        end
      end
      if ({err_len, err_chk, err_tmo} != 3'b000) begin
        chk("err_onehot", $countones({err_len, err_chk, err_tmo}), 1);
        chk("err_width", 32'(err_prev & {err_len, err_chk, err_tmo}), 0);
      end
      if (pkt_valid && !pkt_prev) observe(EV_PKT);
      if (err_len) observe(EV_LEN);
      if (err_chk) observe(EV_CHK);
      if (err_tmo) observe(EV_TMO);
      pkt_prev = pkt_valid;
      err_prev = {err_len, err_chk, err_tmo};
    end
  end

  task automatic push_ev(input int kind, input int len, input int c);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    e.cyc  = c;
    evq.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 last_strobe = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_all();
    while (stim.size() != 0) send(stim.pop_front());
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    rdq.push_back(exp);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (evq.size() != 0 || rdq.size() != 0); i++)
      @(negedge clk);
    chk(name, evq.size() + rdq.size(), 0);
  endtask

  task automatic ack();
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    #1;
    chk("ack_valid", 32'(pkt_valid), 0);
    chk("ack_rx_en", 32'(rx_en), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_addr  = 4'h0;
    rd_req   = 1'b0;
    pkt_ack  = 1'b0;
    #12;
    chk("reset_outs", {pkt_valid, pkt_len, rd_data, busy,
                       err_len, err_chk, err_tmo, rx_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rx_en_idle", 32'(rx_en), 1);

    // basic packet
    push_ev(EV_PKT, 3, 0);
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_all();
    drain("t1_pkt");
    rd(4'd0, 8'h11);
    rd(4'd1, 8'h22);
    rd(4'd2, 8'h33);
    drain("t1_rd");

    // held packet ignores new bytes
    #1 chk("hold_rx_en", 32'(rx_en), 0);
    chk("hold_busy", 32'(busy), 0);
    send(8'h44);
    #1 chk("hold_valid", 32'(pkt_valid), 1);
    chk("hold_len", 32'(pkt_len), 3);
    rd(4'd0, 8'h11);
    drain("t6_rd");
    ack();

    // leading garbage discarded
    push_ev(EV_PKT, 1, 0);
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_all();
    drain("t2_pkt");
    rd(4'd0, 8'h7E);
    drain("t2_rd");
    ack();

    // checksum error, then good packet
    push_ev(EV_CHK, 0, 0);
    stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_all();
    drain("t3_chk");
    #1 chk("t3_valid", 32'(pkt_valid), 0);
    chk("t3_busy", 32'(busy), 0);
    push_ev(EV_PKT, 2, 0);
    stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
    send_all();
    drain("t3_pkt");
    rd(4'd0, 8'hAA);
    rd(4'd1, 8'h55);
    drain("t3_rd");
    ack();

    // illegal lengths, SYNC as length included
    push_ev(EV_LEN, 0, 0);
    push_ev(EV_LEN, 0, 0);
    push_ev(EV_LEN, 0, 0);
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'hA5};
    send_all();
    drain("t4_len");
    #1 chk("t4_busy", 32'(busy), 0);

    // maximum length
    push_ev(EV_PKT, 16, 0);
    stim.push_back(8'hA5);
    stim.push_back(8'h10);
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    stim.push_back(8'h10);
    send_all();
    drain("max_pkt");
    rd(4'd15, 8'h0F);
    rd(4'd7, 8'h07);
    drain("max_rd");
    ack();

    // inter-byte timeout
    stim = '{8'hA5, 8'h02, 8'h10};
    send_all();
    push_ev(EV_TMO, 0, last_strobe + TMO - 1);
    drain("t5_tmo");
    #1 chk("t5_busy", 32'(busy), 0);

    // byte arriving on the expiry cycle wins
    stim = '{8'hA5, 8'h02, 8'h10};
    send_all();
    repeat (TMO - 3) @(negedge clk);
    push_ev(EV_PKT, 2, 0);
    send(8'h20);
    chk("t5_race_gap", last_strobe - cyc + TMO - 1, TMO - 1);
    send(8'h32);
    drain("t5_pkt");
    rd(4'd1, 8'h20);
    drain("t5_rd");
    ack();

    // enable drop aborts silently
    stim = '{8'hA5, 8'h02};
    send_all();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    #1 chk("en_busy", 32'(busy), 0);
    chk("en_rx_en", 32'(rx_en), 0);
    en = 1'b1;
    stim = '{8'h10, 8'h20, 8'h32};
    send_all();
    repeat (3) @(negedge clk);
    chk("en_valid", 32'(pkt_valid), 0);

    // async reset mid-payload
    rd_addr = 4'd1;
    stim = '{8'hA5, 8'h03, 8'h11};
    send_all();
    #1 chk("pay_busy", 32'(busy), 1);
    chk("pay_rd", 32'(rd_data), 32'h20);
    #2 rst = 1'b1;
    #1 chk("rst_outs", {pkt_valid, pkt_len, rd_data, busy,
                        err_len, err_chk, err_tmo, rx_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_ev(EV_PKT, 1, 0);
    stim = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_all();
    drain("post_rst_pkt");
    rd(4'd0, 8'h5A);
    drain("post_rst_rd");
    ack();

    repeat (5) @(negedge clk);
    chk("final_queues", evq.size() + rdq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
